// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx: buffers processor stores and launches one
// transmission at a time, waiting for uart_tx completion between bytes.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en_i,
    input  logic [7:0]    wr_data_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o,
    output logic          ovf_o,
    input  logic          ovf_clr_i,
    output logic          tx_start_o,
    output logic [7:0]    tx_byte_o,
    input  logic          tx_active_i,
    input  logic          tx_done_i
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    state_e        state_q;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          ovf_q;
    logic          ovf_d;
    logic          tx_start_q;
    logic [7:0]    tx_byte_q;

    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;

    // Flags come from the registered count only, so wr_en has no path to them.
    assign full_s  = (count_q == DEPTH_C);
    assign empty_s = (count_q == {(AW+1){1'b0}});
    assign push_s  = wr_en_i & ~full_s;
    assign pop_s   = (state_q == IDLE) & ~empty_s & ~tx_active_i;

    assign full_o     = full_s;
    assign empty_o    = empty_s;
    assign count_o    = count_q;
    assign ovf_o      = ovf_q;
    assign tx_start_o = tx_start_q;
    assign tx_byte_o  = tx_byte_q;

    // Next occupancy and overflow flag; a dropped push beats a clear.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (push_s && !pop_s) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop_s && !push_s) begin
            count_d = count_q - (AW+1)'(1);
        end else begin
            count_d = count_q;
        end
        if (wr_en_i && full_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wptr_q] <= wr_data_i;
        end
    end

    // Write side bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= {AW{1'b0}};
            count_q <= {(AW+1){1'b0}};
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            if (push_s) begin
                wptr_q <= wptr_q + AW'(1);
            end
        end
    end

    // Transmit sequencer: pop in IDLE, pulse start, then hold until tx_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rptr_q     <= {AW{1'b0}};
            tx_start_q <= 1'b0;
            tx_byte_q  <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_start_q <= 1'b0;
                    if (pop_s) begin
                        tx_byte_q  <= mem_q[rptr_q];
                        rptr_q     <= rptr_q + AW'(1);
                        tx_start_q <= 1'b1;
                        state_q    <= START;
                    end
                end
                START: begin
                    tx_start_q <= 1'b0;
                    state_q    <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    tx_start_q <= 1'b0;
                    if (tx_done_i) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    tx_start_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

endmodule
